nibble_serial_adder: RTL and testbench

- Multi-cycle wide adder that sits directly around the team's 4-bit `cla` block. It feeds `cla` one nibble of each operand per cycle and consumes its S/Cout.
- Adds two WIDTH-bit operands in WIDTH/4 cycles, using one `cla` instance plus a registered carry chain.
- Valid/ready handshakes on both sides. Sits between operand-issue logic and a result consumer.

---
 rtl/nibble_serial_adder.sv | 153 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that streams one nibble per cycle through
// a single 4-bit carry-lookahead adder with a registered carry chain.

module cla (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Carries from generate/propagate terms only, no ripple through sums
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign S    = p ^ c[3:0];
  assign Cout = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_nxt;
  logic            sign_a;
  logic            sign_b;
  logic            cout_q;
  logic            ovf_q;
  logic            ov_q;
  logic [3:0]      cla_s;
  logic            cla_co;

  cla u_cla (
    .A    (a_sh[3:0]),
    .B    (b_sh[3:0]),
    .Cin  (carry),
    .S    (cla_s),
    .Cout (cla_co)
  );

  // New nibble enters at the top so the sum ends up aligned after NIB cycles
  if (WIDTH == 4) begin : g_one
    assign s_nxt = cla_s;
  end else begin : g_many
    assign s_nxt = {cla_s, s_q[WIDTH-1:4]};
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = ov_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      s_q    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh   <= A;
            b_sh   <= B;
            carry  <= Cin;
            sign_a <= A[WIDTH-1];
            sign_b <= B[WIDTH-1];
            cnt    <= '0;
            state  <= ADD;
          end
        end
        ADD: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          s_q   <= s_nxt;
          carry <= cla_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NIB - 1)) begin
            state  <= DONE;
            ov_q   <= 1'b1;
            cout_q <= cla_co;
            ovf_q  <= (sign_a == sign_b) && (cla_s[3] != sign_a);
          end
        end
        DONE: begin
          if (out_ready) begin
            ov_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder against an
// arithmetic reference model.

module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide addition, sign rule on the truncated sum
  task automatic ref_add(input  logic [W-1:0] a,
                         input  logic [W-1:0] b,
                         input  logic         c,
                         output logic [W-1:0] s,
                         output logic         co,
                         output logic         ov);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  task automatic do_op(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic         c,
                       input int           stall);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           k;
    int           gap;
    ref_add(a, b, c, es, ec, eo);
    A        = a;
    B        = b;
    Cin      = c;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    if (k == 20) chk("accept_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    gap = 0;
    while (!out_valid && gap < 30) begin
      in_valid = 1'b1;
      A        = W'($urandom);
      step();
      gap++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(gap), 64'(NIB));
    chk("S", 64'(S), 64'(es));
    chk("Cout", 64'(Cout), 64'(ec));
    chk("Ovf", 64'(Ovf), 64'(eo));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      A        = W'($urandom);
      B        = W'($urandom);
      step();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_S", 64'(S), 64'(es));
      chk("stall_Cout", 64'(Cout), 64'(ec));
      chk("stall_Ovf", 64'(Ovf), 64'(eo));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_S", 64'(S), 64'd0);
    chk("rst_Cout", 64'(Cout), 64'd0);
    chk("rst_Ovf", 64'(Ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 0);
    do_op(16'h1234, 16'h4321, 1'b1, 0);
    do_op(16'hA5A5, 16'h5A5A, 1'b1, 5);
    do_op(16'h0F0F, 16'h0001, 1'b0, 0);

    // Reset in the second ADD cycle discards the partial result
    A        = 16'hBEEF;
    B        = 16'h1111;
    Cin      = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rst_add_in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_S", 64'(S), 64'd0);
    chk("midrst_Cout", 64'(Cout), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 0);
    chk("midrst_sum", 64'(S), 64'h1000);

    for (int i = 0; i < 1000; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
